// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions for the instruction fetch path: fetch FSM
// encoding and default datapath widths.
package fetch_unit_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_skid_buf.sv
// Two-entry skid buffer between fetch and decode, built only with
// FETCH_SKID_BUF_EN. Head entry drives the decode outputs directly.
`ifdef FETCH_SKID_BUF_EN
module fetch_skid_buf
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] data_pc,
  output logic                  valid,
  output logic                  space
);

  logic [DATA_WIDTH-1:0] data0, data1;
  logic [ADDR_WIDTH-1:0] pc0, pc1;
  logic [1:0]            count;
  logic                  pop;

  assign valid   = (count != 2'd0);
  // space depends only on the registered fill level, so the fetch side
  // never sees decode's ready combinationally
  assign space   = (count != 2'd2);
  assign pop     = valid && ready;
  assign data    = data0;
  assign data_pc = pc0;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      pc0   <= '0;
      pc1   <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= push_data;
            pc0   <= push_pc;
          end else begin
            data1 <= push_data;
            pc1   <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          pc0   <= pc1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= push_data;
            pc0   <= push_pc;
          end else begin
            data0 <= data1;
            pc0   <= pc1;
            data1 <= push_data;
            pc1   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, IDLE/RUN control and the word handed to
// decode. Define FETCH_SKID_BUF_EN to decouple inst_ready via a skid buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] target_PC,
  output logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_PC,
  output logic                  inst_valid,
  input  logic                  inst_ready
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  active;
  logic                  load;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The start cycle itself already fetches; the halt cycle still fetches.
  always_comb begin
    state_next = state;
    active     = 1'b0;
    case (state)
      IDLE: begin
        active = start;
        if (start && !(redirect && halt)) state_next = RUN;
      end
      RUN: begin
        active = 1'b1;
        if (halt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FETCH_SKID_BUF_EN
  logic space;

  assign load = active && space && !redirect;

  fetch_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect),
    .push     (load),
    .push_data(i_read_data),
    .push_pc  (pc),
    .ready    (inst_ready),
    .data     (instruction),
    .data_pc  (inst_PC),
    .valid    (inst_valid),
    .space    (space)
  );
`else
  assign load = active && (!inst_valid || inst_ready) && !redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_valid  <= 1'b0;
      instruction <= '0;
      inst_PC     <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      instruction <= i_read_data;
      inst_PC     <= pc;
      inst_valid  <= 1'b1;
    end else if (inst_ready) begin
      inst_valid <= 1'b0;
    end
  end
`endif

  // PC wraps naturally at the top of the address space
  always_ff @(posedge clock) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= target_PC;
    else if (load)     pc <= pc + ADDR_WIDTH'(1);
  end

  assign i_address = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, word-address width of the RAM instruction port.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins fetching from the current PC.
REQ-007 SHALL have port halt  input  1  one-cycle pulse; stops fetching after the current cycle.
REQ-008 SHALL have port redirect  input  1  branch/jump taken; replaces PC.
REQ-009 SHALL have port target_PC  input  ADDR_WIDTH  redirect destination.
REQ-010 SHALL have port i_address  output  ADDR_WIDTH  address to RAM instruction port; always equals PC.
REQ-011 SHALL have port i_read_data  input  DATA_WIDTH  RAM instruction data, combinational from i_address.
REQ-012 SHALL have port instruction  output  DATA_WIDTH  registered instruction to decode.
REQ-013 SHALL have port inst_PC  output  ADDR_WIDTH  address the instruction was fetched from.
REQ-014 SHALL have port inst_valid  output  1  instruction/inst_PC hold a valid word.
REQ-015 SHALL have port inst_ready  input  1  decode accepts the word this cycle.

Function
REQ-016 SHALL implement FSM states IDLE, RUN; IDLE->RUN on start; RUN->IDLE on halt; start in RUN and halt in IDLE ignored.
REQ-017 SHALL, in RUN, load i_read_data and PC into the output register and advance PC by 1 when the output register is empty or inst_valid&&inst_ready (transfer).
REQ-018 SHALL hold PC and the output register unchanged when inst_valid=1 and inst_ready=0.
REQ-019 SHALL sustain one instruction per cycle while inst_ready stays high; latency PC->inst_valid is one cycle.
REQ-020 SHALL wrap PC from 2^ADDR_WIDTH-1 to 0 without error.
REQ-021 SHALL, on redirect (any state), set PC<=target_PC and clear inst_valid the next cycle; the word fetched that cycle is discarded.
REQ-022 SHALL give redirect priority over stall and over sequential increment; redirect with halt: PC<=target_PC and go to IDLE.
REQ-023 SHALL, in IDLE, issue no new loads but keep a pending valid word until it is transferred.
REQ-024 SHALL never change instruction/inst_PC while inst_valid=1 and inst_ready=0.

Reset
REQ-025 SHALL, on reset, set state=IDLE, PC=RESET_PC, inst_valid=0, instruction=0, inst_PC=0.
REQ-026 SHALL let reset override start, halt and redirect in the same cycle, and drop any in-flight word when asserted mid-RUN.

Configuration
REQ-027 SHALL support macro FETCH_SKID_BUF_EN: when defined, inst_ready is registered and a 2-entry skid buffer holds words so no combinational path exists from inst_ready to i_address; throughput remains one per cycle.
REQ-028 SHALL, without FETCH_SKID_BUF_EN, use the single output register of REQ-017 with inst_ready feeding the PC-advance logic combinationally.
REQ-029 SHALL make redirect flush both skid entries when FETCH_SKID_BUF_EN is defined; all other observable ordering identical in both builds.

Structure
REQ-030 SHALL place the state encoding (IDLE, RUN) and default DATA_WIDTH/ADDR_WIDTH constants in the shared processor package.
REQ-031 SHALL, when FETCH_SKID_BUF_EN is defined, implement the buffer as sub-module fetch_skid_buf; otherwise no sub-module.

Verification
REQ-032 SHALL test: RAM words 0..3 = 0x11,0x22,0x33,0x44, reset then start, inst_ready=1 -> inst_valid from cycle 1, instruction 0x11,0x22,0x33,0x44 with inst_PC 0,1,2,3 on consecutive cycles.
REQ-033 SHALL test: inst_ready=0 for 3 cycles while instruction=0x22 -> instruction, inst_PC=1 and i_address=2 hold; on release 0x33 follows with no loss or duplicate.
REQ-034 SHALL test: redirect with target_PC=0x0044 while PC=5 -> next cycle inst_valid=0, i_address=0x0044; following cycle instruction=mem[0x44], inst_PC=0x0044.
REQ-035 SHALL test: RESET_PC=0xFFFE, start -> inst_PC sequence 0xFFFE,0xFFFF,0x0000.
REQ-036 SHALL test: halt pulse after inst_PC=2 -> state IDLE, PC frozen at 3, pending word transfers once, then inst_valid=0; reset asserted during RUN -> all outputs return to REQ-025 values next cycle.
REQ-037 SHALL run REQ-032..036 in both FETCH_SKID_BUF_EN builds with identical accepted-instruction sequences.
